// File: rtl/pulse_event_scheduler.sv
// Funnels one-cycle event pulses from NREQ requesters into a single shared pulse
// synchronizer: per-requester pending counters, round-robin grant, ack wait with timeout, gap.
module pulse_event_scheduler #(
  parameter int NREQ    = 4,
  parameter int CNT_W   = 3,
  parameter int MIN_GAP = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                    fast_clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_pulse,
  input  logic                    sync_ack,
  input  logic                    clr_err,
  output logic                    pulse_out,
  output logic [$clog2(NREQ)-1:0] pulse_id,
  output logic                    busy,
  output logic [NREQ-1:0]         overflow,
  output logic                    timeout_err
);
  localparam int ID_W = $clog2(NREQ);
  localparam int WC_W = $clog2(TIMEOUT + 1);
  localparam int GC_W = $clog2(MIN_GAP + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, GAP} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt [NREQ];
  logic [CNT_W-1:0]  cnt_nxt [NREQ];
  logic [NREQ-1:0]   ovf_set;
  logic [ID_W-1:0]   last_grant;
  logic [ID_W-1:0]   pick;
  logic              any_pend;
  logic              grant;
  logic              timeout_hit;
  logic [WC_W-1:0]   wait_cnt;
  logic [GC_W-1:0]   gap_cnt;

  // Scan offsets from the far end down so the nearest requester after last_grant wins.
  always_comb begin
    any_pend = 1'b0;
    pick     = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (cnt[(int'(last_grant) + k) % NREQ] != '0) begin
        any_pend = 1'b1;
        pick     = ID_W'((int'(last_grant) + k) % NREQ);
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    grant       = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (any_pend) begin
          grant     = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT_ACK;
      WAIT_ACK: begin
        if (sync_ack) begin
          state_nxt = GAP;
        end else if (wait_cnt == WC_W'(TIMEOUT)) begin
          timeout_hit = 1'b1;
          state_nxt   = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == GC_W'(MIN_GAP)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A request and a grant in the same cycle cancel; a saturated counter flags overflow instead.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      cnt_nxt[i] = cnt[i];
      ovf_set[i] = 1'b0;
      if (req_pulse[i] && !(grant && pick == ID_W'(i))) begin
        if (cnt[i] == CNT_MAX) ovf_set[i] = 1'b1;
        else                   cnt_nxt[i] = cnt[i] + CNT_W'(1);
      end else if (!req_pulse[i] && grant && pick == ID_W'(i)) begin
        cnt_nxt[i] = cnt[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge fast_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= ID_W'(NREQ - 1);
      pulse_id    <= '0;
      wait_cnt    <= '0;
      gap_cnt     <= '0;
      overflow    <= '0;
      timeout_err <= 1'b0;
      for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
    end else begin
      state <= state_nxt;
      for (int i = 0; i < NREQ; i++) cnt[i] <= cnt_nxt[i];
      if (grant) begin
        last_grant <= pick;
        pulse_id   <= pick;
      end
      if (state == ISSUE)                                 wait_cnt <= WC_W'(1);
      else if (state == WAIT_ACK && state_nxt == WAIT_ACK) wait_cnt <= wait_cnt + WC_W'(1);
      else                                                wait_cnt <= '0;
      if (state == WAIT_ACK && state_nxt == GAP)  gap_cnt <= GC_W'(1);
      else if (state == GAP && state_nxt == GAP)  gap_cnt <= gap_cnt + GC_W'(1);
      else                                        gap_cnt <= '0;
      overflow    <= (overflow & ~{NREQ{clr_err}}) | ovf_set;
      timeout_err <= (timeout_err & ~clr_err) | timeout_hit;
    end
  end

  assign pulse_out = (state == ISSUE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_pulse_event_scheduler.sv
// Bench for pulse_event_scheduler: timestamp-based reference model predicts each pulse
// (edge, id) into a queue; an independent monitor pops and compares on every pulse_out.
module tb_pulse_event_scheduler;
  localparam int NREQ    = 4;
  localparam int CNT_W   = 3;
  localparam int MIN_GAP = 4;
  localparam int TIMEOUT = 15;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic            fast_clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NREQ-1:0] req_pulse = '0;
  logic            sync_ack = 1'b0;
  logic            clr_err = 1'b0;
  logic            pulse_out;
  logic [1:0]      pulse_id;
  logic            busy;
  logic [NREQ-1:0] overflow;
  logic            timeout_err;

  pulse_event_scheduler #(.NREQ(NREQ), .CNT_W(CNT_W), .MIN_GAP(MIN_GAP), .TIMEOUT(TIMEOUT)) dut (
    .fast_clk(fast_clk), .rst_n(rst_n), .req_pulse(req_pulse), .sync_ack(sync_ack),
    .clr_err(clr_err), .pulse_out(pulse_out), .pulse_id(pulse_id), .busy(busy),
    .overflow(overflow), .timeout_err(timeout_err)
  );

  // clock / reset
  always #5 fast_clk = ~fast_clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, expv, $time);
    end
  endtask

  // reference model: pending events per requester, and cycle stamps for the channel
  typedef struct { int ed; int id; } exp_t;
  exp_t            exp_q[$];
  int              mcnt[NREQ];
  int              mlast;
  bit              m_busy;
  int              m_issue;
  int              m_free;
  logic [NREQ-1:0] exp_ovf;
  logic            exp_to;
  int              cyc = 0;
  int              g;
  logic            to_set;
  logic [NREQ-1:0] ovf_set;

  always @(posedge fast_clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (mcnt[i]) mcnt[i] = 0;
      mlast = NREQ - 1; m_busy = 0; m_issue = 0; m_free = 0;
      exp_ovf = '0; exp_to = 1'b0;
      exp_q.delete();
    end else begin
      cyc++;
      g = -1; to_set = 1'b0; ovf_set = '0;
      // ack window: edges issue+2 .. issue+1+TIMEOUT; after that the gap runs MIN_GAP cycles
      if (m_busy && cyc >= m_issue + 2) begin
        if (sync_ack) begin
          m_busy = 0; m_free = cyc + MIN_GAP + 1;
        end else if (cyc == m_issue + 1 + TIMEOUT) begin
          to_set = 1'b1; m_busy = 0; m_free = cyc + MIN_GAP + 1;
        end
      end
      if (!m_busy && cyc >= m_free) begin
        for (int k = 1; k <= NREQ; k++)
          if (g < 0 && mcnt[(mlast + k) % NREQ] > 0) g = (mlast + k) % NREQ;
        if (g >= 0) begin
          m_busy = 1; m_issue = cyc; mlast = g;
          exp_q.push_back('{ed: cyc, id: g});
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_pulse[i] && g != i) begin
          if (mcnt[i] == CMAX) ovf_set[i] = 1'b1;
          else mcnt[i]++;
        end else if (!req_pulse[i] && g == i) begin
          mcnt[i]--;
        end
      end
      exp_ovf = (clr_err ? '0 : exp_ovf) | ovf_set;
      exp_to  = (exp_to && !clr_err) || to_set;
    end
  end

  function automatic bit model_empty();
    int s = 0;
    foreach (mcnt[i]) s += mcnt[i];
    return (s == 0) && !m_busy;
  endfunction

  // monitor
  int pulse_seen = 0;
  int id_hist[NREQ];
  int last_pulse_cyc = -1;
  exp_t e;

  initial foreach (id_hist[i]) id_hist[i] = 0;

  always @(negedge fast_clk) begin
    if (rst_n) begin
      if (exp_q.size() > 0 && exp_q[0].ed < cyc) begin
        check("missed_pulse", 64'(cyc), 64'(exp_q[0].ed));
        void'(exp_q.pop_front());
      end
      if (pulse_out) begin
        pulse_seen++;
        if (!$isunknown(pulse_id)) id_hist[pulse_id]++;
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("pulse_time", 64'(cyc), 64'(e.ed));
          check("pulse_id", 64'(pulse_id), 64'(e.id));
        end
        if (last_pulse_cyc >= 0)
          check("pulse_spacing_ok", 64'(cyc - last_pulse_cyc >= MIN_GAP + 2), 64'(1));
        last_pulse_cyc = cyc;
      end
    end
  end

  // ack responder: ack_delay>0 acks that many cycles after pulse_out, 0 never, <0 random
  int ack_delay = 1;
  int d;
  always begin
    @(negedge fast_clk);
    if (rst_n && pulse_out) begin
      d = ack_delay;
      if (d < 0) d = $urandom_range(1, TIMEOUT + 2);
      if (d > 0) begin
        repeat (d) @(negedge fast_clk);
        sync_ack = 1'b1;
        @(negedge fast_clk);
        sync_ack = 1'b0;
      end
    end
  end

  // driver tasks
  task automatic pulse_req(input logic [NREQ-1:0] m);
    @(negedge fast_clk);
    req_pulse = m;
    @(negedge fast_clk);
    req_pulse = '0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (!(busy === 1'b0 && exp_q.size() == 0 && model_empty()) && n < limit) begin
      @(negedge fast_clk);
      n++;
    end
    check("drain_within_budget", 64'(n < limit), 64'(1));
  endtask

  task automatic wait_pulse(input int limit);
    int n = 0;
    while (pulse_out !== 1'b1 && n < limit) begin
      @(negedge fast_clk);
      n++;
    end
    check("pulse_within_budget", 64'(n < limit), 64'(1));
  endtask

  task automatic pulse_clr();
    @(negedge fast_clk);
    clr_err = 1'b1;
    @(negedge fast_clk);
    clr_err = 1'b0;
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_overflow"}, 64'(overflow), 64'(exp_ovf));
    check({tag, "_timeout_err"}, 64'(timeout_err), 64'(exp_to));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  int snap;

  initial begin
    // reset state
    repeat (2) @(negedge fast_clk);
    check("rst_pulse_out", 64'(pulse_out), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_pulse_id", 64'(pulse_id), 64'(0));
    check("rst_overflow", 64'(overflow), 64'(0));
    check("rst_timeout_err", 64'(timeout_err), 64'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge fast_clk);

    // single request from requester 2, ack 3 cycles after the pulse
    ack_delay = 3;
    @(negedge fast_clk);
    req_pulse = 4'b0100;
    @(negedge fast_clk);
    req_pulse = '0;
    @(negedge fast_clk);
    check("single_pulse_latency", 64'(pulse_out), 64'(1));
    check("single_pulse_id", 64'(pulse_id), 64'(2));
    repeat (7) @(negedge fast_clk);
    check("single_busy_in_gap", 64'(busy), 64'(1));
    @(negedge fast_clk);
    check("single_idle_after_gap", 64'(busy), 64'(0));
    wait_idle(100);

    // all four at once, prompt acks
    ack_delay = 1;
    snap = pulse_seen;
    pulse_req(4'b1111);
    wait_idle(200);
    check("burst_pulse_count", 64'(pulse_seen - snap), 64'(4));

    // saturation of requester 1 while the channel is held in WAIT_ACK; acks land on cycle TIMEOUT
    ack_delay = TIMEOUT;
    pulse_req(4'b0001);
    wait_pulse(20);
    snap = id_hist[1];
    @(negedge fast_clk);
    req_pulse = 4'b0010;
    repeat (9) @(negedge fast_clk);
    req_pulse = '0;
    check("sat_overflow_set", 64'(overflow), 64'(4'b0010));
    wait_idle(600);
    check("sat_id1_pulses", 64'(id_hist[1] - snap), 64'(7));
    check("ack_on_last_cycle_no_err", 64'(timeout_err), 64'(0));
    check_flags("sat");
    pulse_clr();
    check("clr_overflow", 64'(overflow), 64'(0));

    // no ack at all -> timeout after TIMEOUT wait cycles, then next pending requester
    ack_delay = 0;
    pulse_req(4'b1000);
    wait_pulse(20);
    @(negedge fast_clk);
    req_pulse = 4'b0001;
    @(negedge fast_clk);
    req_pulse = '0;
    repeat (13) @(negedge fast_clk);
    check("timeout_not_yet", 64'(timeout_err), 64'(0));
    @(negedge fast_clk);
    check("timeout_set", 64'(timeout_err), 64'(1));
    ack_delay = 2;
    snap = id_hist[0];
    wait_idle(200);
    check("after_timeout_next_id0", 64'(id_hist[0] - snap), 64'(1));
    check_flags("timeout");
    pulse_clr();
    check("clr_timeout_err", 64'(timeout_err), 64'(0));

    // reset while waiting for an ack with events pending
    ack_delay = 0;
    pulse_req(4'b0100);
    wait_pulse(20);
    repeat (3) @(negedge fast_clk);
    pulse_req(4'b1010);
    @(negedge fast_clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_pulse_out", 64'(pulse_out), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_pulse_id", 64'(pulse_id), 64'(0));
    check("midrst_overflow", 64'(overflow), 64'(0));
    check("midrst_timeout_err", 64'(timeout_err), 64'(0));
    repeat (2) @(negedge fast_clk);
    #2 rst_n = 1'b1;
    last_pulse_cyc = -1;
    snap = pulse_seen;
    repeat (30) @(negedge fast_clk);
    check("no_pulse_after_reset", 64'(pulse_seen - snap), 64'(0));
    ack_delay = 1;
    pulse_req(4'b0011);
    wait_pulse(20);
    check("first_grant_after_reset", 64'(pulse_id), 64'(0));
    wait_idle(200);

    // randomized traffic, random ack delays (some past the timeout), occasional clears
    ack_delay = -1;
    for (int t = 0; t < 600; t++) begin
      @(negedge fast_clk);
      req_pulse = ($urandom_range(0, 5) == 0) ? NREQ'($urandom_range(1, 15)) : '0;
      clr_err   = ($urandom_range(0, 40) == 0);
      if (t % 50 == 49) begin
        #1 check_flags("rand");
      end
    end
    @(negedge fast_clk);
    req_pulse = '0;
    clr_err = 1'b0;
    wait_idle(3000);
    check_flags("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
